mac_tx_frame: RTL and testbench
===============================

MAC_TX_FRAME -- requirements
Module: mac_tx_frame

Interface
REQ-001 The module SHALL have a single clock and a synchronous, active-high reset: clk input 1, the sole clock, all logic on its rising edge; rst input 1, synchronous active-high reset.
REQ-002 ptr_fifo_rd  output  1  pop of frame-descriptor FIFO; standard-read FIFO, dout valid the cycle after rd.
REQ-003 ptr_fifo_dout  input  16  descriptor; [11:0] frame length in bytes, FCS excluded; [15:12] ignored.
REQ-004 ptr_fifo_empty  input  1  descriptor FIFO empty.
REQ-005 data_fifo_rd  output  1  pop of frame byte FIFO; dout valid the cycle after rd.
REQ-006 data_fifo_dout  input  8  frame byte.
REQ-007 tx_pause  input  1  level; inhibits starting a new frame.
REQ-008 gmii_tx_en  output  1  registered; transmit enable.
REQ-009 gmii_txd  output  8  registered; transmit byte.
REQ-010 tx_frame_cnt  output  16  frames transmitted, wraps 0xFFFF->0.

Function
REQ-011 The FSM SHALL use states IDLE, LEN, PRE, SFD, DATA, PAD, FCS, IFG.
REQ-012 IDLE: when ptr_fifo_empty=0 and tx_pause=0, pulse ptr_fifo_rd for 1 cycle and go to LEN; otherwise stay.
REQ-013 LEN: latch len=ptr_fifo_dout[11:0]; if len=0 return to IDLE with no data_fifo_rd and no tx_en; else go to PRE.
REQ-014 PRE SHALL drive 7 cycles of tx_en=1, txd=0x55; SFD SHALL drive 1 cycle of 0xD5.
REQ-015 data_fifo_rd SHALL be asserted for exactly len consecutive cycles, starting in the SFD cycle; a byte read in cycle t appears on gmii_txd in cycle t+1 in DATA.
REQ-016 DATA SHALL last exactly len cycles; a 12-bit byte counter compares against len, with no overflow for len up to 4095.
REQ-017 PAD (CRC build only): if len<60, drive 60-len cycles of txd=0x00; if len>=60, skip PAD.
REQ-018 FCS (CRC build only): 4 cycles of CRC-32 over DATA and PAD bytes; IEEE 802.3 reflected polynomial, init 0xFFFFFFFF, final complement, LSB byte first.
REQ-019 IFG SHALL hold tx_en=0 and txd=0x00 for exactly 12 cycles, then go to IDLE.
REQ-020 Back-to-back frames with a descriptor already available SHALL show exactly 14 tx_en-low cycles between frames.
REQ-021 tx_pause SHALL be sampled only in IDLE; assertion mid-frame does not truncate the frame.
REQ-022 tx_frame_cnt SHALL increment in the last cycle of IFG; len=0 descriptors are not counted.
REQ-023 Data availability is guaranteed because upstream writes a descriptor only after all its bytes; no underrun detection.
REQ-024 Outside PRE, SFD, DATA, PAD and FCS, gmii_tx_en=0 and gmii_txd=0x00.

Reset
REQ-025 On rst=1 at a clock edge: state IDLE, ptr_fifo_rd=0, data_fifo_rd=0, gmii_tx_en=0, gmii_txd=0x00, tx_frame_cnt=0, CRC register 0xFFFFFFFF, all counters 0.
REQ-026 Reset asserted mid-frame SHALL drop tx_en on the next edge with no FCS emitted; FIFO contents are not flushed by this block.

Configuration
REQ-027 The macro MAC_TX_CRC_GEN_EN SHALL, when defined, enable PAD and FCS states and the CRC logic per REQ-017/018.
REQ-028 When MAC_TX_CRC_GEN_EN is undefined, no PAD, FCS or CRC logic SHALL exist, and DATA goes directly to IFG; len then includes the upstream-supplied FCS and bytes pass verbatim.

Structure
REQ-029 Package mac_tx_pkg SHALL hold: state enum; PREAMBLE_LEN=7, IFG_LEN=12, MIN_FRAME_LEN=60, FCS_LEN=4, PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5, CRC32_INIT=0xFFFFFFFF, CRC32_POLY=0xEDB88320.
REQ-030 CRC SHALL be a sub-module crc32_d8: byte-per-cycle update with init/enable inputs, instantiated only under MAC_TX_CRC_GEN_EN.

Verification
REQ-031 CRC build, len=60 bytes 0x00..0x3B: 72 tx_en cycles (7x55, D5, 60 data, 4 FCS); FCS matches software CRC-32; tx_frame_cnt=1.
REQ-032 CRC build, len=14: 14 data bytes, 46 bytes 0x00, 4 FCS; 72 tx_en cycles; exactly 14 data_fifo_rd cycles.
REQ-033 Two len=64 descriptors queued: tx_en high 76 cycles, low exactly 14, high 76 cycles; tx_frame_cnt=2.
REQ-034 Descriptor len=0 then len=60: first descriptor popped with no tx_en and no data_fifo_rd; second transmitted normally; tx_frame_cnt=1.
REQ-035 rst pulsed during DATA byte 20 of a len=100 frame: tx_en=0 next cycle; all outputs at reset values; tx_frame_cnt=0.
REQ-036 No-CRC build, len=64: 72 tx_en cycles, 64 bytes verbatim, no pad; tx_pause=1 held in IDLE with a descriptor pending: ptr_fifo_rd stays 0.

Source files
------------

// File: rtl/mac_tx_pkg.sv
// Shared types and constants for the GMII transmit framer.
package mac_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_PRE,
      ST_SFD,
      ST_DATA,
      ST_PAD,
      ST_FCS,
      ST_IFG
   } state_e;

   localparam int unsigned PREAMBLE_LEN  = 7;
   localparam int unsigned IFG_LEN       = 12;
   localparam int unsigned MIN_FRAME_LEN = 60;
   localparam int unsigned FCS_LEN       = 4;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;

endpackage

// File: rtl/crc32_d8.sv
// Byte-per-cycle reflected CRC-32 (IEEE 802.3); init has priority over enable.
module crc32_d8
   import mac_tx_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        init_i,
   input  logic        en_i,
   input  logic [7:0]  data_i,
   output logic [31:0] crc_o
);

   logic [31:0] crc_q, crc_d;

   always_comb begin
      crc_d = crc_q;
      if (init_i) begin
         crc_d = CRC32_INIT;
      end else if (en_i) begin
         crc_d = crc_q ^ {24'h0, data_i};
         for (int i = 0; i < 8; i++) begin
            crc_d = crc_d[0] ? ((crc_d >> 1) ^ CRC32_POLY) : (crc_d >> 1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) crc_q <= CRC32_INIT;
      else     crc_q <= crc_d;
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/mac_tx_frame.sv
// GMII transmit framer: descriptor pop, preamble/SFD, payload, optional pad+FCS, IFG.
// Define MAC_TX_CRC_GEN_EN to enable padding to 60 bytes and FCS generation.
module mac_tx_frame
   import mac_tx_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   output logic        ptr_fifo_rd,
   input  logic [15:0] ptr_fifo_dout,
   input  logic        ptr_fifo_empty,
   output logic        data_fifo_rd,
   input  logic [7:0]  data_fifo_dout,
   input  logic        tx_pause,
   output logic        gmii_tx_en,
   output logic [7:0]  gmii_txd,
   output logic [15:0] tx_frame_cnt
);

   state_e      state_q, state_d;
   logic [11:0] len_q, len_d;
   logic [11:0] cnt_q, cnt_d;
   logic        tx_en_q, tx_en_d;
   logic [7:0]  txd_q, txd_d;
   logic [15:0] frm_cnt_q, frm_cnt_d;
   logic        ptr_rd_c, data_rd_c;
   logic        unused_desc_bits;

   assign unused_desc_bits = ^ptr_fifo_dout[15:12];

`ifdef MAC_TX_CRC_GEN_EN
   logic        crc_init, crc_en;
   logic [7:0]  crc_byte;
   logic [31:0] crc_val, fcs;

   assign fcs = ~crc_val;

   crc32_d8 u_crc (
      .clk    (clk),
      .rst    (rst),
      .init_i (crc_init),
      .en_i   (crc_en),
      .data_i (crc_byte),
      .crc_o  (crc_val)
   );
`endif

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      tx_en_d   = 1'b0;
      txd_d     = 8'h00;
      frm_cnt_d = frm_cnt_q;
      ptr_rd_c  = 1'b0;
      data_rd_c = 1'b0;
`ifdef MAC_TX_CRC_GEN_EN
      crc_init  = 1'b0;
      crc_en    = 1'b0;
      crc_byte  = data_fifo_dout;
`endif
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!ptr_fifo_empty && !tx_pause) begin
               ptr_rd_c = 1'b1;
               state_d  = ST_LEN;
            end
         end
         ST_LEN: begin
            len_d   = ptr_fifo_dout[11:0];
            cnt_d   = '0;
            state_d = (ptr_fifo_dout[11:0] == 12'd0) ? ST_IDLE : ST_PRE;
         end
         ST_PRE: begin
            tx_en_d = 1'b1;
            txd_d   = PREAMBLE_BYTE;
            if (cnt_q == 12'(PREAMBLE_LEN - 1)) begin
               cnt_d   = '0;
               state_d = ST_SFD;
            end else begin
               cnt_d = cnt_q + 12'd1;
            end
         end
         ST_SFD: begin
            // First payload pop happens here so byte 0 is on dout in the first DATA cycle.
            tx_en_d   = 1'b1;
            txd_d     = SFD_BYTE;
            data_rd_c = 1'b1;
            cnt_d     = '0;
            state_d   = ST_DATA;
`ifdef MAC_TX_CRC_GEN_EN
            crc_init  = 1'b1;
`endif
         end
         ST_DATA: begin
            tx_en_d   = 1'b1;
            txd_d     = data_fifo_dout;
            data_rd_c = (cnt_q != len_q - 12'd1);
`ifdef MAC_TX_CRC_GEN_EN
            crc_en    = 1'b1;
`endif
            if (cnt_q == len_q - 12'd1) begin
`ifdef MAC_TX_CRC_GEN_EN
               if (len_q < 12'(MIN_FRAME_LEN)) begin
                  cnt_d   = cnt_q + 12'd1;
                  state_d = ST_PAD;
               end else begin
                  cnt_d   = '0;
                  state_d = ST_FCS;
               end
`else
               cnt_d   = '0;
               state_d = ST_IFG;
`endif
            end else begin
               cnt_d = cnt_q + 12'd1;
            end
         end
`ifdef MAC_TX_CRC_GEN_EN
         ST_PAD: begin
            // Counter keeps running from len, so PAD ends at the 60th byte position.
            tx_en_d  = 1'b1;
            crc_en   = 1'b1;
            crc_byte = 8'h00;
            if (cnt_q == 12'(MIN_FRAME_LEN - 1)) begin
               cnt_d   = '0;
               state_d = ST_FCS;
            end else begin
               cnt_d = cnt_q + 12'd1;
            end
         end
         ST_FCS: begin
            tx_en_d = 1'b1;
            txd_d   = 8'(fcs >> {cnt_q[1:0], 3'b000});
            if (cnt_q == 12'(FCS_LEN - 1)) begin
               cnt_d   = '0;
               state_d = ST_IFG;
            end else begin
               cnt_d = cnt_q + 12'd1;
            end
         end
`endif
         ST_IFG: begin
            if (cnt_q == 12'(IFG_LEN - 1)) begin
               cnt_d     = '0;
               frm_cnt_d = frm_cnt_q + 16'd1;
               state_d   = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 12'd1;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         len_q     <= '0;
         cnt_q     <= '0;
         tx_en_q   <= 1'b0;
         txd_q     <= 8'h00;
         frm_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         tx_en_q   <= tx_en_d;
         txd_q     <= txd_d;
         frm_cnt_q <= frm_cnt_d;
      end
   end

   // FIFO pops are combinational from state; hold them off while reset is asserted.
   assign ptr_fifo_rd  = ptr_rd_c  & ~rst;
   assign data_fifo_rd = data_rd_c & ~rst;
   assign gmii_tx_en   = tx_en_q;
   assign gmii_txd     = txd_q;
   assign tx_frame_cnt = frm_cnt_q;

endmodule

// File: tb/tb_mac_tx_frame.sv
// Randomized bench for mac_tx_frame: FIFO models, GMII monitor, expected-stream model.
module tb_mac_tx_frame;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tx_pause = 1'b0;
   logic        ptr_fifo_rd, data_fifo_rd, gmii_tx_en, ptr_empty;
   logic [7:0]  gmii_txd;
   logic [15:0] tx_frame_cnt;
   logic [15:0] ptr_dout = '0;
   logic [7:0]  dat_dout = '0;

   always #5 clk = ~clk;

   mac_tx_frame dut (
      .clk            (clk),
      .rst            (rst),
      .ptr_fifo_rd    (ptr_fifo_rd),
      .ptr_fifo_dout  (ptr_dout),
      .ptr_fifo_empty (ptr_empty),
      .data_fifo_rd   (data_fifo_rd),
      .data_fifo_dout (dat_dout),
      .tx_pause       (tx_pause),
      .gmii_tx_en     (gmii_tx_en),
      .gmii_txd       (gmii_txd),
      .tx_frame_cnt   (tx_frame_cnt)
   );

   // Standard-read FIFOs: write side owned by the stimulus, read side by this block.
   logic [15:0] ptr_mem [0:255];
   logic [7:0]  dat_mem [0:8191];
   int p_wr = 0, p_rd = 0, d_wr = 0, d_rd = 0;
   logic flush = 1'b0;

   assign ptr_empty = (p_wr == p_rd);

   always @(posedge clk) begin
      if (flush) begin
         p_rd <= p_wr;
         d_rd <= d_wr;
      end else begin
         if (ptr_fifo_rd && p_rd != p_wr) begin
            ptr_dout <= ptr_mem[p_rd];
            p_rd     <= p_rd + 1;
         end
         if (data_fifo_rd && d_rd != d_wr) begin
            dat_dout <= dat_mem[d_rd];
            d_rd     <= d_rd + 1;
         end
      end
   end

   // GMII monitor: splits the tx_en stream into frames and measures gaps.
   logic [7:0] rx [0:16383];
   int rx_n = 0, frm_n = 0, cur_len = 0, low_run = 0;
   int frm_start [0:255];
   int frm_len [0:255];
   int gap_before [0:255];
   int rd_total = 0, prd_total = 0, bad_idle = 0;
   bit in_frame = 1'b0, seen = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         in_frame <= 1'b0;
         seen     <= 1'b0;
         low_run  <= 0;
         cur_len  <= 0;
      end else begin
         if (data_fifo_rd) rd_total <= rd_total + 1;
         if (ptr_fifo_rd) prd_total <= prd_total + 1;
         if (!gmii_tx_en && gmii_txd !== 8'h00) bad_idle <= bad_idle + 1;
         if (gmii_tx_en) begin
            rx[rx_n] <= gmii_txd;
            rx_n     <= rx_n + 1;
            low_run  <= 0;
            if (!in_frame) begin
               frm_start[frm_n]  <= rx_n;
               gap_before[frm_n] <= seen ? low_run : -1;
               in_frame          <= 1'b1;
               cur_len           <= 1;
            end else begin
               cur_len <= cur_len + 1;
            end
         end else begin
            low_run <= low_run + 1;
            if (in_frame) begin
               frm_len[frm_n] <= cur_len;
               frm_n          <= frm_n + 1;
               in_frame       <= 1'b0;
               seen           <= 1'b1;
            end
         end
      end
   end

   // Expected wire image per frame, built from the frame format rules.
   logic [7:0]  exp_b [0:16383];
   int          exp_nb = 0, exp_n = 0;
   int          exp_start [0:255];
   int          exp_len [0:255];
   logic [31:0] crc_tab [0:255];
   logic [15:0] exp_cnt = '0;
   int          checks = 0, errors = 0;

   task automatic init_crc_tab();
      for (int n = 0; n < 256; n++) begin
         logic [31:0] c;
         c = 32'(n);
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
         crc_tab[n] = c;
      end
   endtask

   task automatic push_frame(input int len, input bit incr);
      logic [7:0]  b;
      logic [31:0] crc;
      int          s;
      crc = 32'hFFFF_FFFF;
      s   = exp_nb;
      if (len > 0) begin
         for (int i = 0; i < 7; i++) begin exp_b[exp_nb] = 8'h55; exp_nb++; end
         exp_b[exp_nb] = 8'hD5; exp_nb++;
      end
      for (int i = 0; i < len; i++) begin
         b = incr ? 8'(i) : 8'($urandom);
         dat_mem[d_wr + i] = b;
         exp_b[exp_nb] = b; exp_nb++;
         crc = crc_tab[8'(crc ^ 32'(b))] ^ (crc >> 8);
      end
      d_wr += len;
`ifdef MAC_TX_CRC_GEN_EN
      if (len > 0) begin
         for (int i = len; i < 60; i++) begin
            exp_b[exp_nb] = 8'h00; exp_nb++;
            crc = crc_tab[8'(crc)] ^ (crc >> 8);
         end
         crc = ~crc;
         for (int k = 0; k < 4; k++) begin exp_b[exp_nb] = crc[8*k +: 8]; exp_nb++; end
      end
`endif
      if (len > 0) begin
         exp_start[exp_n] = s;
         exp_len[exp_n]   = exp_nb - s;
         exp_n++;
         exp_cnt++;
      end
      ptr_mem[p_wr] = {4'($urandom), 12'(len)};
      p_wr++;
   endtask

   task automatic wait_quiet(input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(p_rd == p_wr && d_rd == d_wr && !in_frame && low_run >= 16) && n < budget);
      if (n >= budget) begin
         checks++; errors++;
         $display("FAIL wait_quiet: no idle after %0d cycles", budget);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (gmii_tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en: got %b want 0", gmii_tx_en); end
      checks++; if (gmii_txd !== 8'h00) begin errors++; $display("FAIL reset_txd: got %h want 00", gmii_txd); end
      checks++; if (tx_frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", tx_frame_cnt); end
      checks++; if (ptr_fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_ptr_rd: got %b want 0", ptr_fifo_rd); end
      checks++; if (data_fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_data_rd: got %b want 0", data_fifo_rd); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_frame(input string name, input int len, input bit incr);
      int f0, e0, r0, mism;
      f0 = frm_n; e0 = exp_n; r0 = rd_total;
      push_frame(len, incr);
      wait_quiet(len + 400);
      checks++; if (frm_n - f0 !== 1) begin errors++; $display("FAIL %s_frames: got %0d want 1", name, frm_n - f0); end
      checks++; if (frm_len[f0] !== exp_len[e0]) begin errors++; $display("FAIL %s_txen_cycles: got %0d want %0d", name, frm_len[f0], exp_len[e0]); end
      mism = -1;
      for (int i = 0; i < exp_len[e0]; i++)
         if (mism < 0 && rx[frm_start[f0] + i] !== exp_b[exp_start[e0] + i]) mism = i;
      checks++; if (mism >= 0) begin errors++; $display("FAIL %s_bytes: idx %0d got %h want %h", name, mism, rx[frm_start[f0] + mism], exp_b[exp_start[e0] + mism]); end
      checks++; if (rd_total - r0 !== len) begin errors++; $display("FAIL %s_data_rd: got %0d want %0d", name, rd_total - r0, len); end
      checks++; if (tx_frame_cnt !== exp_cnt) begin errors++; $display("FAIL %s_frame_cnt: got %0d want %0d", name, tx_frame_cnt, exp_cnt); end
   endtask

   // fixed_len=0 picks random lengths; all descriptors are queued before the first pops.
   task automatic test_back_to_back(input string name, input int nfr, input int fixed_len);
      int f0, e0, r0, mism, tot;
      f0 = frm_n; e0 = exp_n; r0 = rd_total; tot = 0;
      for (int k = 0; k < nfr; k++) begin
         int l;
         l = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 120));
         tot += l;
         push_frame(l, 1'b0);
      end
      wait_quiet(nfr * 300);
      checks++; if (frm_n - f0 !== nfr) begin errors++; $display("FAIL %s_frames: got %0d want %0d", name, frm_n - f0, nfr); end
      for (int k = 0; k < nfr; k++) begin
         checks++; if (frm_len[f0 + k] !== exp_len[e0 + k]) begin errors++; $display("FAIL %s_len%0d: got %0d want %0d", name, k, frm_len[f0 + k], exp_len[e0 + k]); end
         mism = -1;
         for (int i = 0; i < exp_len[e0 + k]; i++)
            if (mism < 0 && rx[frm_start[f0 + k] + i] !== exp_b[exp_start[e0 + k] + i]) mism = i;
         checks++; if (mism >= 0) begin errors++; $display("FAIL %s_bytes%0d: idx %0d got %h want %h", name, k, mism, rx[frm_start[f0 + k] + mism], exp_b[exp_start[e0 + k] + mism]); end
         if (k > 0) begin
            checks++; if (gap_before[f0 + k] !== 14) begin errors++; $display("FAIL %s_gap%0d: got %0d want 14", name, k, gap_before[f0 + k]); end
         end
      end
      checks++; if (rd_total - r0 !== tot) begin errors++; $display("FAIL %s_data_rd: got %0d want %0d", name, rd_total - r0, tot); end
      checks++; if (tx_frame_cnt !== exp_cnt) begin errors++; $display("FAIL %s_frame_cnt: got %0d want %0d", name, tx_frame_cnt, exp_cnt); end
   endtask

   task automatic test_zero_len();
      int f0, e0, r0, p0, mism;
      f0 = frm_n; e0 = exp_n; r0 = rd_total; p0 = prd_total;
      push_frame(0, 1'b0);
      push_frame(60, 1'b0);
      wait_quiet(500);
      checks++; if (prd_total - p0 !== 2) begin errors++; $display("FAIL zero_ptr_rd: got %0d want 2", prd_total - p0); end
      checks++; if (frm_n - f0 !== 1) begin errors++; $display("FAIL zero_frames: got %0d want 1", frm_n - f0); end
      checks++; if (rd_total - r0 !== 60) begin errors++; $display("FAIL zero_data_rd: got %0d want 60", rd_total - r0); end
      mism = -1;
      for (int i = 0; i < exp_len[e0]; i++)
         if (mism < 0 && rx[frm_start[f0] + i] !== exp_b[exp_start[e0] + i]) mism = i;
      checks++; if (mism >= 0 || frm_len[f0] !== exp_len[e0]) begin errors++; $display("FAIL zero_second_frame: idx %0d len %0d want len %0d", mism, frm_len[f0], exp_len[e0]); end
      checks++; if (tx_frame_cnt !== exp_cnt) begin errors++; $display("FAIL zero_frame_cnt: got %0d want %0d", tx_frame_cnt, exp_cnt); end
   endtask

   task automatic test_pause();
      int f0, e0, n, mism;
      bit leak;
      f0 = frm_n; e0 = exp_n; leak = 1'b0;
      tx_pause = 1'b1;
      push_frame(50, 1'b0);
      repeat (30) begin
         @(negedge clk);
         if (ptr_fifo_rd || gmii_tx_en) leak = 1'b1;
      end
      checks++; if (leak !== 1'b0) begin errors++; $display("FAIL pause_hold: got activity %b want 0", leak); end
      checks++; if (p_wr - p_rd !== 1) begin errors++; $display("FAIL pause_pending: got %0d want 1", p_wr - p_rd); end
      tx_pause = 1'b0;
      n = 0;
      while (!gmii_tx_en && n < 40) begin @(negedge clk); n++; end
      tx_pause = 1'b1;
      wait_quiet(400);
      tx_pause = 1'b0;
      mism = -1;
      for (int i = 0; i < exp_len[e0]; i++)
         if (mism < 0 && rx[frm_start[f0] + i] !== exp_b[exp_start[e0] + i]) mism = i;
      checks++; if (frm_n - f0 !== 1 || frm_len[f0] !== exp_len[e0] || mism >= 0) begin errors++; $display("FAIL pause_midframe: frames %0d len %0d want len %0d idx %0d", frm_n - f0, frm_len[f0], exp_len[e0], mism); end
   endtask

   task automatic test_reset_mid();
      int n;
      push_frame(100, 1'b0);
      n = 0;
      while (!(in_frame && cur_len >= 28) && n < 200) begin @(negedge clk); n++; end
      checks++; if (n >= 200) begin errors++; $display("FAIL rstmid_reach: got %0d cycles want <200", n); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (gmii_tx_en !== 1'b0) begin errors++; $display("FAIL rstmid_tx_en: got %b want 0", gmii_tx_en); end
      checks++; if (gmii_txd !== 8'h00) begin errors++; $display("FAIL rstmid_txd: got %h want 00", gmii_txd); end
      checks++; if (data_fifo_rd !== 1'b0 || ptr_fifo_rd !== 1'b0) begin errors++; $display("FAIL rstmid_rd: got %b%b want 00", ptr_fifo_rd, data_fifo_rd); end
      checks++; if (tx_frame_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_cnt: got %0d want 0", tx_frame_cnt); end
      rst = 1'b0;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      exp_cnt = '0;
      repeat (20) @(negedge clk);
      checks++; if (gmii_tx_en !== 1'b0 || tx_frame_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_after: tx_en %b cnt %0d want 0 0", gmii_tx_en, tx_frame_cnt); end
   endtask

   task automatic test_idle_txd();
      checks++; if (bad_idle !== 0) begin errors++; $display("FAIL idle_txd_zero: got %0d nonzero idle bytes want 0", bad_idle); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      init_crc_tab();
      test_reset();
      test_single_frame("len60", 60, 1'b1);
      test_single_frame("len14", 14, 1'b0);
      test_back_to_back("b2b64", 2, 64);
      test_zero_len();
      test_back_to_back("rand", 6, 0);
      test_pause();
      test_reset_mid();
      test_single_frame("len64", 64, 1'b0);
      test_idle_txd();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
